// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared types and geometry defaults for the sprite blitter
package chip8_pkg;

    localparam int DEF_SCREEN_W = 128;
    localparam int DEF_SCREEN_H = 64;
    localparam int DEF_HPOS_W   = 7;
    localparam int DEF_VPOS_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCAN,
        RD,
        WR,
        DONE
    } blit_state_t;

    // All-ones pixel value for a given depth (a lit pixel), right-justified in a byte.
    function automatic logic [7:0] pixel_on(input int width);
        pixel_on = 8'((1 << width) - 1);
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - sprite RAM and VRAM bus between blitter and memories
interface sprite_blitter_if #(
    parameter int ADDR_W  = 12,
    parameter int HPOS_W  = 7,
    parameter int VPOS_W  = 6,
    parameter int PIXEL_W = 2
);
    logic [ADDR_W-1:0]  ram_addr;
    logic [7:0]         ram_dout;
    logic [HPOS_W-1:0]  vram_hpos;
    logic [VPOS_W-1:0]  vram_vpos;
    logic [PIXEL_W-1:0] vram_pixelo;
    logic [PIXEL_W-1:0] vram_pixeli;
    logic               vram_we;

    modport master (
        output ram_addr,
        input  ram_dout,
        output vram_hpos,
        output vram_vpos,
        input  vram_pixelo,
        output vram_pixeli,
        output vram_we
    );

    modport slave (
        input  ram_addr,
        output ram_dout,
        input  vram_hpos,
        input  vram_vpos,
        output vram_pixelo,
        input  vram_pixeli,
        input  vram_we
    );
endinterface

// File: rtl/sprite_row_fetch.sv
// rtl/sprite_row_fetch.sv - reads one sprite row (1 or 2 bytes) into a left-justified shift register
module sprite_row_fetch
    import chip8_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              two_bytes,
    input  logic              shift,
    input  logic [ADDR_W-1:0] base,
    input  logic [3:0]        row,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [15:0]       pattern,
    output logic              valid
);
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] row_off;

    assign row_off  = two_bytes ? ADDR_W'({row, 1'b0}) : ADDR_W'(row);
    assign ram_addr = base + row_off + ADDR_W'(two_bytes && (cnt != 2'd0));
    assign valid    = active && (cnt == (two_bytes ? 2'd2 : 2'd1));

    // RAM data lags the address by one cycle, so byte k lands when cnt == k+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 2'd0;
            pattern <= 16'h0000;
        end else if (active) begin
            cnt <= valid ? 2'd0 : cnt + 2'd1;
            if (cnt == 2'd1) pattern <= {ram_dout, 8'h00};
            if (cnt == 2'd2) pattern[7:0] <= ram_dout;
        end else begin
            cnt <= 2'd0;
            if (shift) pattern <= {pattern[14:0], 1'b0};
        end
    end
endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - DXYN sprite draw engine: XOR rows from RAM into VRAM with collision detect
module sprite_blitter
    import chip8_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int HPOS_W   = DEF_HPOS_W,
    parameter int VPOS_W   = DEF_VPOS_W,
    parameter int ADDR_W   = 12,
    parameter int PIXEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] base,
    input  logic              wide,
    input  logic              wrap_en,
    output logic              busy,
    output logic              done,
    output logic              collision,
    sprite_blitter_if.master  bus
);
    blit_state_t state, state_next;

    logic [HPOS_W-1:0] ox;
    logic [VPOS_W-1:0] oy;
    logic              is_wide;
    logic [3:0]        row_last;
    logic [3:0]        row;
    logic [3:0]        col;
    logic [ADDR_W-1:0] base_q;
    logic              wrap_q;
    logic              coll_acc;
    logic              collision_q;
    logic [HPOS_W-1:0] hpos;
    logic [VPOS_W-1:0] vpos;

    logic [15:0]       pattern;
    logic              fetch_valid;
    logic              fetch_active;
    logic              advance;

    logic [HPOS_W:0]   px;
    logic [VPOS_W:0]   py;
    logic              visible;
    logic              draw_pixel;
    logic              col_last;
    blit_state_t       after_col;

    sprite_row_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk       (clk),
        .reset     (reset),
        .active    (fetch_active),
        .two_bytes (is_wide),
        .shift     (advance),
        .base      (base_q),
        .row       (row),
        .ram_addr  (bus.ram_addr),
        .ram_dout  (bus.ram_dout),
        .pattern   (pattern),
        .valid     (fetch_valid)
    );

    // The carry bit of px/py flags a pixel past the right/bottom edge; wrap just drops it.
    assign px         = {1'b0, ox} + (HPOS_W+1)'(col);
    assign py         = {1'b0, oy} + (VPOS_W+1)'(row);
    assign visible    = wrap_q || (!px[HPOS_W] && !py[VPOS_W]);
    assign draw_pixel = pattern[15] && visible;
    assign col_last   = is_wide ? (col == 4'd15) : (col == 4'd7);
    assign after_col  = !col_last ? SCAN : ((row == row_last) ? DONE : FETCH);

    always_comb begin
        state_next   = state;
        fetch_active = 1'b0;
        advance      = 1'b0;
        case (state)
            IDLE:  if (start) state_next = ((n == 4'd0) && !wide) ? DONE : FETCH;
            FETCH: begin
                fetch_active = 1'b1;
                if (fetch_valid) state_next = SCAN;
            end
            SCAN: begin
                if (draw_pixel) begin
                    state_next = RD;
                end else begin
                    advance    = 1'b1;
                    state_next = after_col;
                end
            end
            RD:    state_next = WR;
            WR: begin
                advance    = 1'b1;
                state_next = after_col;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ox          <= '0;
            oy          <= '0;
            is_wide     <= 1'b0;
            row_last    <= 4'd0;
            row         <= 4'd0;
            col         <= 4'd0;
            base_q      <= '0;
            wrap_q      <= 1'b0;
            coll_acc    <= 1'b0;
            collision_q <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    ox       <= HPOS_W'(x);
                    oy       <= VPOS_W'(y);
                    is_wide  <= wide && (n == 4'd0);
                    row_last <= (wide && (n == 4'd0)) ? 4'd15 : n - 4'd1;
                    base_q   <= base;
                    wrap_q   <= wrap_en;
                    coll_acc <= 1'b0;
                    row      <= 4'd0;
                    col      <= 4'd0;
                end
                SCAN: if (draw_pixel) begin
                    hpos <= px[HPOS_W-1:0];
                    vpos <= py[VPOS_W-1:0];
                end
                WR:   if (bus.vram_pixelo != '0) coll_acc <= 1'b1;
                DONE: collision_q <= coll_acc;
                default: ;
            endcase
            if (advance) begin
                if (col_last) begin
                    col <= 4'd0;
                    row <= row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    assign busy            = (state == FETCH) || (state == SCAN) || (state == RD) || (state == WR);
    assign done            = (state == DONE);
    assign collision       = done ? coll_acc : collision_q;
    assign bus.vram_hpos   = hpos;
    assign bus.vram_vpos   = vpos;
    assign bus.vram_we     = (state == WR);
    assign bus.vram_pixeli = (state == WR) ? (bus.vram_pixelo ^ PIXEL_W'(pixel_on(PIXEL_W))) : '0;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed and randomized draws checked against a pixel-level reference
module tb_sprite_blitter;
    localparam int SW = 128;
    localparam int SH = 64;
    localparam int AW = 12;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    x = '0, y = '0;
    logic [3:0]    n = '0;
    logic [AW-1:0] base = '0;
    logic          wide = 1'b0, wrap_en = 1'b0;
    logic          busy, done, collision;

    sprite_blitter_if #(.ADDR_W(AW), .HPOS_W(7), .VPOS_W(6), .PIXEL_W(PW)) bus ();

    sprite_blitter #(
        .SCREEN_W(SW), .SCREEN_H(SH), .HPOS_W(7), .VPOS_W(6), .ADDR_W(AW), .PIXEL_W(PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x         (x),
        .y         (y),
        .n         (n),
        .base      (base),
        .wide      (wide),
        .wrap_en   (wrap_en),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem      [0:4095];
    logic [1:0]  vram     [0:SH-1][0:SW-1];
    logic [1:0]  exp_vram [0:SH-1][0:SW-1];
    logic        vram_clear = 1'b0;
    logic [14:0] wr_log[$];
    logic [14:0] exp_log[$];
    logic        exp_coll;
    int          exp_cycles;
    int          we_cnt = 0, done_cnt = 0;
    int          vectors = 0, miscompares = 0;

    always @(posedge clk) begin
        bus.ram_dout    <= mem[bus.ram_addr];
        bus.vram_pixelo <= vram[bus.vram_vpos][bus.vram_hpos];
        if (vram_clear) begin
            for (int r = 0; r < SH; r++)
                for (int c = 0; c < SW; c++) vram[r][c] <= 2'b00;
        end else if (bus.vram_we) begin
            vram[bus.vram_vpos][bus.vram_hpos] <= bus.vram_pixeli;
        end
    end

    always @(negedge clk) begin
        if (bus.vram_we === 1'b1) begin
            wr_log.push_back({bus.vram_vpos, bus.vram_hpos, bus.vram_pixeli});
            we_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_screen();
        @(negedge clk) vram_clear = 1'b1;
        @(negedge clk) vram_clear = 1'b0;
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) exp_vram[r][c] = 2'b00;
    endtask

    // Reference: walk the sprite bitmap in draw order, toggling model VRAM.
    task automatic model_draw(input logic [7:0] mx, my, input logic [3:0] mn,
                              input logic [AW-1:0] mb, input logic mw, mwr);
        int ox, oy, ncols, nrows, lit, px, py;
        logic big;
        logic [15:0] pat;
        logic [1:0] old;
        ox = int'(mx) % SW;
        oy = int'(my) % SH;
        big = mw && (mn == 4'd0);
        ncols = big ? 16 : 8;
        nrows = big ? 16 : int'(mn);
        exp_log.delete();
        exp_coll = 1'b0;
        lit = 0;
        for (int r = 0; r < nrows; r++) begin
            if (big) pat = {mem[(int'(mb) + 2*r) % 4096], mem[(int'(mb) + 2*r + 1) % 4096]};
            else     pat = {mem[(int'(mb) + r) % 4096], 8'h00};
            for (int c = 0; c < ncols; c++) begin
                px = ox + c;
                py = oy + r;
                if (mwr) begin
                    px = px % SW;
                    py = py % SH;
                end
                if (pat[15-c] && px < SW && py < SH) begin
                    old = exp_vram[py][px];
                    if (old != 2'b00) exp_coll = 1'b1;
                    exp_vram[py][px] = old ^ 2'b11;
                    exp_log.push_back({6'(py), 7'(px), old ^ 2'b11});
                    lit++;
                end
            end
        end
        exp_cycles = 1 + nrows * ((big ? 3 : 2) + ncols) + 2 * lit + 1;
    endtask

    task automatic draw(input string tag, input logic [7:0] dx, dy, input logic [3:0] dn,
                        input logic [AW-1:0] db, input logic dw, dwr, input bit poke,
                        output int cyc);
        int errs;
        model_draw(dx, dy, dn, db, dw, dwr);
        wr_log.delete();
        @(negedge clk);
        x = dx; y = dy; n = dn; base = db; wide = dw; wrap_en = dwr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 4 && done !== 1'b1) begin
                start = 1'b1; x = dx + 8'd37; n = 4'd15; wide = ~dw;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " cycles"}, cyc, exp_cycles);
        chk({tag, " collision"}, 32'(collision), 32'(exp_coll));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        chk({tag, " collision_held"}, 32'(collision), 32'(exp_coll));
        chk({tag, " write_count"}, wr_log.size(), exp_log.size());
        for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++)
            chk($sformatf("%s write[%0d]", tag, i), 32'(wr_log[i]), 32'(exp_log[i]));
        errs = 0;
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                if (vram[r][c] !== exp_vram[r][c]) errs++;
        chk({tag, " vram_bad_pixels"}, errs, 0);
    endtask

    initial begin
        int cyc, we0, done0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) begin
                vram[r][c] = 2'b00;
                exp_vram[r][c] = 2'b00;
            end
        bus.ram_dout = 8'h00;
        bus.vram_pixelo = 2'b00;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst collision", 32'(collision), 0);
        chk("rst vram_we", 32'(bus.vram_we), 0);
        chk("rst ram_addr", 32'(bus.ram_addr), 0);
        chk("rst hpos", 32'(bus.vram_hpos), 0);
        chk("rst vpos", 32'(bus.vram_vpos), 0);
        chk("rst pixeli", 32'(bus.vram_pixeli), 0);

        clear_screen();
        mem[12'h200] = 8'hF0;
        draw("f0_first", 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, 1'b0, 1'b1, cyc);
        chk("f0_first cycles20", cyc, 20);
        chk("f0_first writes4", wr_log.size(), 4);
        for (int c = 0; c < 5; c++)
            chk($sformatf("f0_first pix%0d", c), 32'(vram[0][c]), (c < 4) ? 32'd3 : 32'd0);
        draw("f0_redraw", 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, 1'b0, 1'b0, cyc);
        chk("f0_redraw coll1", 32'(collision), 1);
        chk("f0_redraw pix0", 32'(vram[0][0]), 0);

        for (int i = 0; i < 4; i++) mem[12'h210 + i] = 8'hFF;
        clear_screen();
        draw("clip", 8'd124, 8'd62, 4'd4, 12'h210, 1'b0, 1'b0, 1'b0, cyc);
        chk("clip writes8", wr_log.size(), 8);
        clear_screen();
        draw("wrap", 8'd124, 8'd62, 4'd4, 12'h210, 1'b0, 1'b1, 1'b0, cyc);
        chk("wrap writes32", wr_log.size(), 32);
        chk("wrap pix_1_3", 32'(vram[1][3]), 3);

        for (int i = 0; i < 32; i++) mem[12'h300 + i] = 8'hFF;
        clear_screen();
        draw("wide", 8'd200, 8'd0, 4'd0, 12'h300, 1'b1, 1'b0, 1'b0, cyc);
        chk("wide writes256", wr_log.size(), 256);
        chk("wide pix_15_87", 32'(vram[15][87]), 3);
        chk("wide pix_0_71", 32'(vram[0][71]), 0);

        draw("n0", 8'd5, 8'd5, 4'd0, 12'h300, 1'b0, 1'b0, 1'b0, cyc);
        chk("n0 cycles2", cyc, 2);
        chk("n0 writes0", wr_log.size(), 0);

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 10; k++)
            draw($sformatf("rnd%0d", k), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), k == 3, cyc);

        for (int i = 0; i < 4; i++) mem[12'h400 + i] = 8'hFF;
        @(negedge clk);
        x = 8'd10; y = 8'd10; n = 4'd4; base = 12'h400; wide = 1'b0; wrap_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst collision", 32'(collision), 0);
        chk("midrst vram_we", 32'(bus.vram_we), 0);
        we0 = we_cnt;
        done0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("midrst no_writes", we_cnt - we0, 0);
        chk("midrst no_done", done_cnt - done0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
